seg_scan_n: RTL and testbench

Parametrised multiplexed 7-segment driver for an N-digit common-anode display.
- Sequentially converts a binary value to BCD (double-dabble), then time-multiplexes the digits with per-digit decimal points.
- Adds leading-zero blanking, overflow indication and configurable polarity/refresh.
- Sits between the fare/distance datapath and the board display pins.

---
 rtl/seg_pkg.sv | 64 ++++++
 rtl/seg_bin2bcd.sv | 101 ++++++++++
 rtl/seg_scan_n.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_n.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seg_scan_n display driver:
// segment glyphs, converter state type and constant helper functions.
package seg_pkg;

    // Glyphs are active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input longint v);
        int r;
        r = 1;
        for (int i = 1; i < 63; i++) begin
            if ((longint'(1) << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble converter: one iteration per clock, with an
// overflow flag evaluated against 10^DIGITS-1 when the input is captured.
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  sys_reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int                CNT_W = clog2(longint'(DATA_W) + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);
    localparam logic [63:0]       LIMIT = pow10(DIGITS) - 64'd1;

    conv_state_e          state_q, state_d;
    logic [DATA_W-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic [4*DIGITS-1:0]  adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (64'(data) > LIMIT);
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = {adj[4*DIGITS-2:0], bin_q[DATA_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/seg_scan_n.sv
// Multiplexed N-digit 7-segment driver: free-running BCD conversion, digit scan,
// leading-zero blanking, overflow dashes. Define SEG_SCAN_BLINK_EN for per-digit blink.
module seg_scan_n
    import seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DATA_W         = 14,
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int DWELL_HZ       = 1000,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_HZ       = 2
`endif
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic [DATA_W-1:0]  data,
    input  logic [DIGITS-1:0]  point,
    input  logic               blank_lz,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]  blink_mask,
`endif
    output logic               busy,
    output logic               overflow,
    output logic [DIGITS-1:0]  seg_sel,
    output logic [7:0]         seg_led
);

    localparam int                DWELL_CNT  = CLK_FREQ_HZ / DWELL_HZ;
    localparam int                DW_W       = clog2(longint'(DWELL_CNT));
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_CNT - 1);
    localparam int                IDX_W      = clog2(longint'(DIGITS));
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        LED_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic                 conv_busy, conv_done, conv_ovf;
    logic [4*DIGITS-1:0]  conv_bcd;

    seg_bin2bcd #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk       (clk),
        .sys_reset (sys_reset),
        .start     (1'b1),
        .data      (data),
        .busy      (conv_busy),
        .done      (conv_done),
        .bcd       (conv_bcd),
        .overflow  (conv_ovf)
    );

    logic [DW_W-1:0]      dwell_q, dwell_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 scan_on_q, scan_on_d;
    logic [4*DIGITS-1:0]  disp_bcd_q, disp_bcd_d;
    logic                 disp_ovf_q, disp_ovf_d;
    logic [DIGITS-1:0]    sel_q, sel_d;
    logic [7:0]           led_q, led_d;
    logic                 tick;

    // The first tick only arms the scan, so digit 0 is always shown first.
    always_comb begin
        tick       = (dwell_q == DWELL_LAST);
        dwell_d    = tick ? '0 : dwell_q + 1'b1;
        idx_d      = idx_q;
        scan_on_d  = scan_on_q | tick;
        disp_bcd_d = disp_bcd_q;
        disp_ovf_d = disp_ovf_q;
        if (tick && scan_on_q) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (conv_done) begin
            disp_bcd_d = conv_bcd;
            disp_ovf_d = conv_ovf;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int               BLINK_CNT  = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int               BL_W       = clog2(longint'(BLINK_CNT));
    localparam logic [BL_W-1:0]  BLINK_LAST = BL_W'(BLINK_CNT - 1);

    logic [BL_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_off_q, blink_off_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`endif

    logic [DIGITS-1:0]  lz_blank;
    logic               all_zero;

    // Digit k>0 blanks when it and every digit above it are zero.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            all_zero    = all_zero && (disp_bcd_q[4*k +: 4] == 4'd0);
            lz_blank[k] = all_zero;
        end
    end

    logic [3:0]         cur_nib;
    logic               cur_lz, cur_dp, cur_blink;
    logic [6:0]         glyph;
    logic [7:0]         led_low;
    logic [DIGITS-1:0]  onehot;

    always_comb begin
        cur_nib   = 4'd0;
        cur_lz    = 1'b0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        onehot    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = disp_bcd_q[4*k +: 4];
                cur_lz    = lz_blank[k];
                cur_dp    = point[k];
                onehot[k] = 1'b1;
`ifdef SEG_SCAN_BLINK_EN
                cur_blink = blink_mask[k];
`endif
            end
        end

        glyph = seg_code(cur_nib);
        if (disp_ovf_q) begin
            glyph = SEG_DASH;
        end else if (blank_lz && cur_lz) begin
            glyph = SEG_BLANK;
        end
        led_low = {~cur_dp, glyph};
`ifdef SEG_SCAN_BLINK_EN
        if (blink_off_q && cur_blink) begin
            led_low = 8'hFF;
        end
`endif

        led_d = (SEG_ACTIVE_LOW != 0) ? led_low : ~led_low;
        sel_d = (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
        if (!scan_on_q) begin
            led_d = LED_OFF;
            sel_d = SEL_OFF;
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            dwell_q    <= '0;
            idx_q      <= '0;
            scan_on_q  <= 1'b0;
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
            sel_q      <= SEL_OFF;
            led_q      <= LED_OFF;
        end else begin
            dwell_q    <= dwell_d;
            idx_q      <= idx_d;
            scan_on_q  <= scan_on_d;
            disp_bcd_q <= disp_bcd_d;
            disp_ovf_q <= disp_ovf_d;
            sel_q      <= sel_d;
            led_q      <= led_d;
        end
    end

    assign busy     = conv_busy;
    assign overflow = disp_ovf_q;
    assign seg_sel  = sel_q;
    assign seg_led  = led_q;

endmodule

// File: tb/tb_seg_scan_n.sv
// Self-checking bench for seg_scan_n: expected digit frames are queued when data
// is applied and compared as the scan presents each digit.
module tb_seg_scan_n;

    localparam int DIGITS   = 4;
    localparam int DATA_W   = 14;
    localparam int CLK_HZ   = 1000;
    localparam int DWELL_HZ = 100;
    localparam int DWELL    = CLK_HZ / DWELL_HZ;
    localparam int CONV     = DATA_W + 2;
    localparam int LIMIT    = 10**DIGITS - 1;

    logic               clk;
    logic               sys_reset;
    logic [DATA_W-1:0]  data;
    logic [DIGITS-1:0]  point;
    logic               blank_lz;
    logic               busy;
    logic               overflow;
    logic [DIGITS-1:0]  seg_sel;
    logic [7:0]         seg_led;
`ifdef SEG_SCAN_BLINK_EN
    logic [DIGITS-1:0]  blink_mask;
`endif

    seg_scan_n #(
        .DIGITS         (DIGITS),
        .DATA_W         (DATA_W),
        .CLK_FREQ_HZ    (CLK_HZ),
        .DWELL_HZ       (DWELL_HZ),
        .SEL_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1)
`ifdef SEG_SCAN_BLINK_EN
        ,
        .BLINK_HZ       (20)
`endif
    ) dut (
        .clk        (clk),
        .sys_reset  (sys_reset),
        .data       (data),
        .point      (point),
        .blank_lz   (blank_lz),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .busy       (busy),
        .overflow   (overflow),
        .seg_sel    (seg_sel),
        .seg_led    (seg_led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    function automatic logic [7:0] model_led(input int k, input int value,
                                             input logic [DIGITS-1:0] pt, input logic blz);
        logic [6:0] g;
        int upper;
        upper = value / (10**k);
        if (value > LIMIT)             g = 7'b0111111;
        else if (blz && k > 0 && upper == 0) g = 7'b1111111;
        else                           g = glyph_tab[upper % 10];
        return {~pt[k], g};
    endfunction

    typedef struct packed {
        logic [2:0]        dig;
        logic [DIGITS-1:0] sel;
        logic [7:0]        led;
    } frame_t;

    frame_t sb_q[$];

    task automatic push_scan(input int value);
        frame_t f;
        for (int k = 0; k < DIGITS; k++) begin
            f.dig = 3'(k);
            f.sel = ~(DIGITS'(1) << k);
            f.led = model_led(k, value, point, blank_lz);
            sb_q.push_back(f);
        end
    endtask

    task automatic drain_scan(input string tag);
        frame_t f;
        int n;
        n = 0;
        while (seg_sel !== 4'b1110 && n < 3 * DWELL * DIGITS) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_align"}, 32'(seg_sel), 32'h0000_000E);
        while (sb_q.size() > 0) begin
            f = sb_q.pop_front();
            chk($sformatf("%s_d%0d_sel", tag, f.dig), 32'(seg_sel), 32'(f.sel));
            chk($sformatf("%s_d%0d_led", tag, f.dig), 32'(seg_led), 32'(f.led));
            repeat (DWELL) @(negedge clk);
        end
    endtask

    task automatic wait_busy(input logic level, input string tag);
        int n;
        n = 0;
        while (busy !== level && n < 4 * CONV) begin
            @(negedge clk);
            n++;
        end
        if (busy !== level) chk({tag, "_timeout"}, 32'(busy), 32'(level));
    endtask

    task automatic apply(input int value, input logic [DIGITS-1:0] pt, input logic blz, input string tag);
        data     = DATA_W'(value);
        point    = pt;
        blank_lz = blz;
        repeat (2 * CONV) @(negedge clk);
        push_scan(value);
        drain_scan(tag);
    endtask

    initial begin
        int busy_len;
        int n;
        sys_reset = 1'b0;
        data      = DATA_W'(1234);
        point     = 4'b0100;
        blank_lz  = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_sel",  32'(seg_sel),  32'h0000_000F);
        chk("rst_led",  32'(seg_led),  32'h0000_00FF);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);

        sys_reset = 1'b1;
        repeat (DWELL) @(negedge clk);
        chk("pre_tick_sel", 32'(seg_sel), 32'h0000_000F);
        @(negedge clk);
        chk("first_sel", 32'(seg_sel), 32'h0000_000E);
        chk("first_led", 32'(seg_led), 32'h0000_00C0);

        repeat (2 * CONV) @(negedge clk);
        push_scan(1234);
        drain_scan("v1234");

        apply(7, 4'b0000, 1'b1, "v7_blz");
        apply(7, 4'b0000, 1'b0, "v7_noblz");
        apply(305, 4'b0001, 1'b1, "v305_blz");

        data  = DATA_W'(10000);
        point = 4'b0010;
        repeat (2 * CONV) @(negedge clk);
        chk("ovf_set", 32'(overflow), 32'd1);
        push_scan(10000);
        drain_scan("v10000");

        data  = DATA_W'(9999);
        point = 4'b0000;
        n = 0;
        while (overflow !== 1'b0 && n < 2 * CONV) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_clear", 32'(overflow), 32'd0);
        push_scan(9999);
        drain_scan("v9999");

        // New data arriving mid-conversion waits for the next capture.
        data = DATA_W'(42);
        wait_busy(1'b0, "b42_fall");
        wait_busy(1'b1, "b42_rise");
        busy_len = 0;
        while (busy === 1'b1 && busy_len < 4 * CONV) begin
            busy_len++;
            if (busy_len == 3) data = DATA_W'(57);
            @(negedge clk);
        end
        chk("busy_len", 32'(busy_len), 32'(DATA_W + 1));
        chk("commit_42", 32'(dut.disp_bcd_q), 32'h0000_0042);
        wait_busy(1'b1, "b57_rise");
        wait_busy(1'b0, "b57_fall");
        chk("commit_57", 32'(dut.disp_bcd_q), 32'h0000_0057);

        repeat (DWELL + 3) @(negedge clk);
        #2 sys_reset = 1'b0;
        #1;
        chk("midrst_sel",  32'(seg_sel),  32'h0000_000F);
        chk("midrst_led",  32'(seg_led),  32'h0000_00FF);
        chk("midrst_busy", 32'(busy),     32'd0);
        point    = 4'b0000;
        blank_lz = 1'b1;
        @(negedge clk);
        sys_reset = 1'b1;
        repeat (DWELL) @(negedge clk);
        chk("restart_pre_sel", 32'(seg_sel), 32'h0000_000F);
        @(negedge clk);
        chk("restart_sel", 32'(seg_sel), 32'h0000_000E);
        chk("restart_led", 32'(seg_led), 32'h0000_00C0);

        apply(57, 4'b1000, 1'b1, "v57_blz");

`ifdef SEG_SCAN_BLINK_EN
        begin
            int n_on, n_off, n_bad, n_other;
            n_on = 0; n_off = 0; n_bad = 0; n_other = 0;
            data       = DATA_W'(5);
            point      = 4'b0000;
            blank_lz   = 1'b0;
            blink_mask = 4'b0001;
            repeat (2 * CONV) @(negedge clk);
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (seg_sel === 4'b1110) begin
                    if (seg_led === 8'h92)      n_on++;
                    else if (seg_led === 8'hFF) n_off++;
                    else                        n_bad++;
                end else if (seg_led !== 8'hC0) begin
                    n_other++;
                end
            end
            chk("blink_bad",     32'(n_bad),   32'd0);
            chk("blink_other",   32'(n_other), 32'd0);
            chk("blink_seen_on", 32'(n_on > 0),  32'd1);
            chk("blink_seen_off", 32'(n_off > 0), 32'd1);
            blink_mask = '0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
